// File: rtl/instr_fetch.sv
// Instruction-fetch stage: holds the fetch PC, runs a req/ack instruction-memory port
// and feeds ID through registered outputs backed by a one-entry skid buffer.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic [31:0] i_branch_pc,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic        o_ce
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        DROP = 2'd2
    } state_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    state_e      state_q, state_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] redir_q, redir_d;
    logic        ce_q, ce_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic        skid_v_q, skid_v_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;

    logic        ack_s;
    logic        take_s;
    logic        out_free_s;
    logic [31:0] branch_s;

    assign ack_s      = req_q & i_imem_ack;
    assign take_s     = ack_s & (state_q == PEND);
    assign out_free_s = ~ce_q | ~i_stall;
    assign branch_s   = word_align(i_branch_pc);

    // Next-state: flush redirect first, otherwise output/skid routing and fetch sequencing
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        redir_d      = redir_q;
        ce_d         = ce_q;
        instr_d      = instr_q;
        pc_d         = pc_q;
        skid_v_d     = skid_v_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;

        if (i_flush) begin
            ce_d     = 1'b0;
            instr_d  = NOP;
            skid_v_d = 1'b0;
            case (state_q)
                IDLE: begin
                    state_d = PEND;
                    addr_d  = branch_s;
                end
                PEND: begin
                    if (ack_s) begin
                        state_d = PEND;
                        addr_d  = branch_s;
                    end else begin
                        // request must stay stable until acked, so park the target
                        state_d = DROP;
                        redir_d = branch_s;
                    end
                end
                DROP: begin
                    state_d = DROP;
                    redir_d = branch_s;
                end
                default: begin
                    state_d = IDLE;
                    addr_d  = branch_s;
                end
            endcase
        end else begin
            if (out_free_s) begin
                if (skid_v_q) begin
                    ce_d         = 1'b1;
                    instr_d      = skid_instr_q;
                    pc_d         = skid_pc_q;
                    skid_v_d     = take_s;
                    skid_instr_d = i_imem_rdata;
                    skid_pc_d    = addr_q;
                end else if (take_s) begin
                    ce_d    = 1'b1;
                    instr_d = i_imem_rdata;
                    pc_d    = addr_q;
                end else begin
                    ce_d    = 1'b0;
                    instr_d = NOP;
                end
            end else begin
                if (take_s) begin
                    skid_v_d     = 1'b1;
                    skid_instr_d = i_imem_rdata;
                    skid_pc_d    = addr_q;
                end else begin
                    skid_v_d     = skid_v_q;
                end
            end

            case (state_q)
                IDLE: begin
                    if (!skid_v_q) begin
                        state_d = PEND;
                    end else begin
                        state_d = IDLE;
                    end
                end
                PEND: begin
                    if (ack_s) begin
                        addr_d = addr_q + 32'd4;
                        // a word parked in the skid stops fetching until it drains
                        if (out_free_s && !skid_v_q) begin
                            state_d = PEND;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        state_d = PEND;
                    end
                end
                DROP: begin
                    if (ack_s) begin
                        state_d = PEND;
                        addr_d  = redir_q;
                    end else begin
                        state_d = DROP;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        req_d = (state_d != IDLE);
    end

    // State, fetch address, output and skid registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            req_q        <= 1'b0;
            addr_q       <= RESET_PC;
            redir_q      <= RESET_PC;
            ce_q         <= 1'b0;
            instr_q      <= NOP;
            pc_q         <= RESET_PC;
            skid_v_q     <= 1'b0;
            skid_instr_q <= NOP;
            skid_pc_q    <= RESET_PC;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            addr_q       <= addr_d;
            redir_q      <= redir_d;
            ce_q         <= ce_d;
            instr_q      <= instr_d;
            pc_q         <= pc_d;
            skid_v_q     <= skid_v_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

    assign o_imem_req  = req_q;
    assign o_imem_addr = addr_q;
    assign o_ce        = ce_q;
    assign o_instr     = instr_q;
    assign o_pc        = pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: per-cycle vector table for req/addr/ce/pc plus a
// scoreboard of acked words that must reach ID in order.
module tb_instr_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_stall = 1'b0;
    logic        i_flush = 1'b0;
    logic [31:0] i_branch_pc = 32'd0;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_ack = 1'b0;
    logic [31:0] i_imem_rdata = 32'd0;
    logic [31:0] o_instr;
    logic [31:0] o_pc;
    logic        o_ce;

    instr_fetch dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_stall      (i_stall),
        .i_flush      (i_flush),
        .i_branch_pc  (i_branch_pc),
        .o_imem_req   (o_imem_req),
        .o_imem_addr  (o_imem_addr),
        .i_imem_ack   (i_imem_ack),
        .i_imem_rdata (i_imem_rdata),
        .o_instr      (o_instr),
        .o_pc         (o_pc),
        .o_ce         (o_ce)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        flush;
        logic        ack;
        logic [31:0] bpc;
        logic [31:0] rdata;
        logic        ereq;
        logic [31:0] eaddr;
        logic        ece;
        logic [31:0] epc;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    logic drop_pending = 1'b0;

    function automatic void add(input logic rst, input logic stall, input logic flush,
                                input logic ack, input logic [31:0] bpc, input logic [31:0] rdata,
                                input logic ereq, input logic [31:0] eaddr,
                                input logic ece, input logic [31:0] epc);
        vec_t v;
        v.rst = rst; v.stall = stall; v.flush = flush; v.ack = ack;
        v.bpc = bpc; v.rdata = rdata;
        v.ereq = ereq; v.eaddr = eaddr; v.ece = ece; v.epc = epc;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        exp_t e;
        //   rst  stl  fl   ack  bpc           rdata          req  addr          ce   pc
        // stream with zero wait states
        add(1'b1,1'b0,1'b0,1'b0,32'h0,        32'h0,         1'b0,32'h0,       1'b0,32'h0);
        add(1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,         1'b0,32'h0,       1'b0,32'h0);
        add(1'b0,1'b0,1'b0,1'b1,32'h0,        32'h0000_0013, 1'b1,32'h0,       1'b0,32'h0);
        add(1'b0,1'b0,1'b0,1'b1,32'h0,        32'h0084_0393, 1'b1,32'h4,       1'b1,32'h0);
        add(1'b0,1'b0,1'b0,1'b1,32'h0,        32'h0043_1663, 1'b1,32'h8,       1'b1,32'h4);
        add(1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,         1'b1,32'hC,       1'b1,32'h8);
        // stall with skid fill, then drain
        add(1'b1,1'b0,1'b0,1'b0,32'h0,        32'h0,         1'b0,32'h0,       1'b0,32'h0);
        add(1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,         1'b0,32'h0,       1'b0,32'h0);
        add(1'b0,1'b0,1'b0,1'b1,32'h0,        32'h0010_0093, 1'b1,32'h0,       1'b0,32'h0);
        add(1'b0,1'b1,1'b0,1'b1,32'h0,        32'h0020_0113, 1'b1,32'h4,       1'b1,32'h0);
        add(1'b0,1'b1,1'b0,1'b0,32'h0,        32'h0,         1'b0,32'h8,       1'b1,32'h0);
        add(1'b0,1'b1,1'b0,1'b0,32'h0,        32'h0,         1'b0,32'h8,       1'b1,32'h0);
        add(1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,         1'b0,32'h8,       1'b1,32'h0);
        add(1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,         1'b0,32'h8,       1'b1,32'h4);
        // flush while pending: stale word at 0x8 is dropped
        add(1'b0,1'b0,1'b1,1'b0,32'h14,       32'h0,         1'b1,32'h8,       1'b0,32'h0);
        add(1'b0,1'b0,1'b0,1'b1,32'h0,        32'hDEAD_BEEF, 1'b1,32'h8,       1'b0,32'h0);
        add(1'b0,1'b0,1'b0,1'b1,32'h0,        32'h0030_0193, 1'b1,32'h14,      1'b0,32'h0);
        // flush + stall + ack together, unaligned target
        add(1'b0,1'b1,1'b1,1'b1,32'h23,       32'h0BAD_BAD0, 1'b1,32'h18,      1'b1,32'h14);
        add(1'b0,1'b0,1'b0,1'b1,32'h0,        32'h0040_0213, 1'b1,32'h20,      1'b0,32'h0);
        // back-to-back flushes, last target wins, then wrap
        add(1'b0,1'b0,1'b1,1'b0,32'h40,       32'h0,         1'b1,32'h24,      1'b1,32'h20);
        add(1'b0,1'b0,1'b1,1'b0,32'hFFFF_FFFC,32'h0,         1'b1,32'h24,      1'b0,32'h0);
        add(1'b0,1'b0,1'b0,1'b1,32'h0,        32'h0BAD_F00D, 1'b1,32'h24,      1'b0,32'h0);
        add(1'b0,1'b0,1'b0,1'b1,32'h0,        32'h0050_0293, 1'b1,32'hFFFF_FFFC,1'b0,32'h0);
        add(1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0,         1'b1,32'h0,       1'b1,32'hFFFF_FFFC);

        @(posedge clk); #1;
        foreach (tbl[i]) begin
            rst_n        = ~tbl[i].rst;
            i_stall      = tbl[i].stall;
            i_flush      = tbl[i].flush;
            i_branch_pc  = tbl[i].bpc;
            i_imem_ack   = tbl[i].ack;
            i_imem_rdata = tbl[i].rdata;
            @(negedge clk);
            chk($sformatf("v%0d req", i), {31'd0, o_imem_req}, {31'd0, tbl[i].ereq});
            chk($sformatf("v%0d addr", i), o_imem_addr, tbl[i].eaddr);
            chk($sformatf("v%0d ce", i), {31'd0, o_ce}, {31'd0, tbl[i].ece});
            if (tbl[i].ece) begin
                chk($sformatf("v%0d pc", i), o_pc, tbl[i].epc);
            end else begin
                chk($sformatf("v%0d nop", i), o_instr, NOP);
            end
            // scoreboard: consume output, then account for this cycle's transfer
            if (tbl[i].rst) begin
                sb.delete();
                drop_pending = 1'b0;
            end else begin
                if (o_ce && !i_stall && !i_flush) begin
                    if (sb.size() == 0) begin
                        chk($sformatf("v%0d sb_empty", i), 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk($sformatf("v%0d sb_pc", i), o_pc, e.pc);
                        chk($sformatf("v%0d sb_instr", i), o_instr, e.instr);
                    end
                end
                if (i_flush) begin
                    sb.delete();
                    if (o_imem_req && !i_imem_ack) drop_pending = 1'b1;
                end else if (o_imem_req && i_imem_ack) begin
                    if (drop_pending) begin
                        drop_pending = 1'b0;
                    end else begin
                        e.pc = o_imem_addr;
                        e.instr = i_imem_rdata;
                        sb.push_back(e);
                    end
                end
            end
            @(posedge clk); #1;
        end
        chk("sb_drained", sb.size(), 32'd0);

        // asynchronous reset in the middle of an outstanding request
        i_stall = 1'b0; i_flush = 1'b0; i_imem_ack = 1'b0; i_branch_pc = 32'd0;
        #2;
        chk("pre_rst_req", {31'd0, o_imem_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_req", {31'd0, o_imem_req}, 32'd0);
        chk("async_ce", {31'd0, o_ce}, 32'd0);
        chk("async_instr", o_instr, NOP);
        chk("async_addr", o_imem_addr, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rerelease_req", {31'd0, o_imem_req}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
